// File: rtl/ahb_bus_arbiter.sv
// Multi-master AHB arbiter: round-robin one-hot HGRANT, re-arbitration only at legal burst boundaries.
// Define AHB_ARB_TENURE_EN to cap INCR bursts at MAX_TENURE beats when another master is waiting.
module ahb_bus_arbiter #(
  parameter int MASTER_NUM     = 4,
  parameter int HBURST_WIDTH   = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input  logic                          HCLK,
  input  logic                          HRST,
  input  logic [MASTER_NUM-1:0]         HBUSREQ,
  input  logic [MASTER_NUM-1:0]         HLOCK,
  input  logic [1:0]                    HTRANS,
  input  logic [HBURST_WIDTH-1:0]       HBURST,
  input  logic                          HREADY,
  input  logic                          HRESP,
  output logic [MASTER_NUM-1:0]         HGRANT,
  output logic [$clog2(MASTER_NUM)-1:0] HMASTER,
  output logic                          HMASTLOCK
);
  localparam int IW = $clog2(MASTER_NUM);
  // beat counter saturates; wide enough for 16-beat bursts and the tenure limit
  localparam int CW = (MAX_TENURE > 16) ? $clog2(MAX_TENURE + 1) : 5;
  localparam logic [IW-1:0]         DEF_IDX = IW'(DEFAULT_MASTER);
  localparam logic [MASTER_NUM-1:0] ONE     = MASTER_NUM'(1);

  typedef enum logic [1:0] {PARK, GRANT, BURST, LOCKED} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]         owner, rr_idx, cand, idx_nxt;
  logic [MASTER_NUM-1:0] grant_nxt;
  logic                  rr_found, regrant;
  logic [2:0]            burst;
  logic [CW-1:0]         cnt, beat_num, blen;
  logic                  idle, busy, nonseq, beat, last, incr_drop, idle_rp, ten_rp, rp;

  assign burst  = HBURST[2:0];
  assign idle   = HTRANS == 2'b00;
  assign busy   = HTRANS == 2'b01;
  assign nonseq = HTRANS == 2'b10;
  assign beat   = HREADY && HTRANS[1];

  always_comb begin
    blen = '0;
    case (burst)
      3'd0:       blen = CW'(1);
      3'd2, 3'd3: blen = CW'(4);
      3'd4, 3'd5: blen = CW'(8);
      3'd6, 3'd7: blen = CW'(16);
      default:    blen = '0;
    endcase
  end

  assign beat_num  = nonseq ? CW'(1) : cnt + CW'(1);
  assign last      = beat && burst != 3'd1 && beat_num == blen;
  assign incr_drop = beat && burst == 3'd1 && !HBUSREQ[owner];
  // a fresh grantee idles until HMASTER hands it the bus; don't bounce the grant meanwhile
  assign idle_rp   = idle && !(state == GRANT && HBUSREQ[owner]);
  assign rp        = HREADY && !busy && (idle_rp || last || incr_drop || HRESP || ten_rp);

  // round-robin search owner+1 .. owner, owner itself last
  always_comb begin
    rr_idx   = DEF_IDX;
    rr_found = 1'b0;
    cand     = owner;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      cand = IW'((int'(owner) + i) % MASTER_NUM);
      if (!rr_found && HBUSREQ[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

`ifdef AHB_ARB_TENURE_EN
  localparam int TW = $clog2(MAX_TENURE + 1);
  logic [TW-1:0] ten_cnt;

  assign ten_rp = beat && burst == 3'd1 && (int'(ten_cnt) + 1 >= MAX_TENURE) &&
                  |(HBUSREQ & ~HGRANT);

  always_ff @(posedge HCLK or negedge HRST) begin
    if (!HRST)
      ten_cnt <= '0;
    else if (HREADY) begin
      if (regrant && rr_idx != owner)
        ten_cnt <= '0;
      else if (beat && burst == 3'd1 && int'(ten_cnt) < MAX_TENURE)
        ten_cnt <= ten_cnt + TW'(1);
    end
  end
`else
  assign ten_rp = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRST) begin
    if (!HRST) state <= PARK;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (HREADY) begin
      if (rp) begin
        if (HLOCK[owner])  state_nxt = LOCKED;
        else if (rr_found) state_nxt = GRANT;
        else               state_nxt = PARK;
      end else if (nonseq && state != LOCKED)
        state_nxt = HLOCK[owner] ? LOCKED : BURST;
    end
  end

  always_comb begin
    regrant   = rp && !HLOCK[owner];
    idx_nxt   = regrant ? rr_idx : owner;
    grant_nxt = ONE << idx_nxt;
  end

  always_ff @(posedge HCLK or negedge HRST) begin
    if (!HRST) begin
      HGRANT    <= ONE << DEF_IDX;
      owner     <= DEF_IDX;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      cnt       <= '0;
    end else if (HREADY) begin
      HGRANT    <= grant_nxt;
      owner     <= idx_nxt;
      HMASTER   <= owner;
      HMASTLOCK <= HLOCK[owner];
      if (beat)
        cnt <= nonseq ? CW'(1) : ((&cnt) ? cnt : cnt + CW'(1));
    end
  end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: reset, round-robin, fixed burst with waits, lock, ERROR, INCR tenure.
module tb_ahb_bus_arbiter;
  localparam logic [1:0] IDLE = 2'd0, NSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3, INCR8 = 3'd5;
`ifdef AHB_ARB_TENURE_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic       HCLK = 1'b0, HRST = 1'b0;
  logic [3:0] HBUSREQ, HLOCK, HGRANT;
  logic [1:0] HTRANS, HMASTER;
  logic [2:0] HBURST;
  logic       HREADY, HRESP, HMASTLOCK;
  int         n_chk = 0, n_fail = 0;

  logic [3:0] rr_exp [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] b8_tr  [10] = '{NSEQ, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
  logic       b8_rdy [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0] lk_tr  [9]  = '{NSEQ, SEQ, SEQ, SEQ, IDLE, NSEQ, SEQ, SEQ, SEQ};

  ahb_bus_arbiter #(.MASTER_NUM(4), .HBURST_WIDTH(3), .DEFAULT_MASTER(0), .MAX_TENURE(16)) dut (
    .HCLK(HCLK), .HRST(HRST), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP), .HGRANT(HGRANT),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs, then sample 1ns after the rising edge
  task automatic cyc(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] tr,
                     input logic [2:0] bu, input logic rdy, input logic rsp);
    HBUSREQ = req; HLOCK = lock; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp;
    @(posedge HCLK); #1;
  endtask

  task automatic do_reset();
    HRST = 1'b0;
    cyc(4'b0, 4'b0, IDLE, SINGLE, 1'b1, 1'b0);
    cyc(4'b0, 4'b0, IDLE, SINGLE, 1'b1, 1'b0);
    HRST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and idle park
    do_reset();
    chk("rst_grant", HGRANT, 4'b0001);
    chk("rst_master", HMASTER, 0);
    chk("rst_mlock", HMASTLOCK, 0);
    cyc(4'b0, 4'b0, IDLE, SINGLE, 1'b1, 1'b0);
    chk("idle_grant", HGRANT, 4'b0001);
    chk("idle_master", HMASTER, 0);

    // round-robin of SINGLE transfers, all masters requesting
    for (int m = 0; m < 4; m++) begin
      cyc(4'hF, 4'b0, NSEQ, SINGLE, 1'b1, 1'b0);
      chk($sformatf("rr_grant%0d", m), HGRANT, rr_exp[m]);
      chk($sformatf("rr_mst_old%0d", m), HMASTER, m);
      cyc(4'hF, 4'b0, IDLE, SINGLE, 1'b1, 1'b0);
      chk($sformatf("rr_mst_new%0d", m), HMASTER, (m + 1) % 4);
    end

    // master 2 INCR8 with two wait states on beat 3
    do_reset();
    cyc(4'b0100, 4'b0, IDLE, SINGLE, 1'b1, 1'b0);
    chk("b8_grant0", HGRANT, 4'b0100);
    cyc(4'b0110, 4'b0, IDLE, SINGLE, 1'b1, 1'b0);
    chk("b8_master0", HMASTER, 2);
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0110, 4'b0, b8_tr[i], INCR8, b8_rdy[i], 1'b0);
      chk($sformatf("b8_grant_s%0d", i), HGRANT, (i == 9) ? 4'b0010 : 4'b0100);
      chk($sformatf("b8_master_s%0d", i), HMASTER, 2);
    end

    // master 1 locked over two INCR4 bursts while master 3 waits
    do_reset();
    cyc(4'b1010, 4'b0010, IDLE, SINGLE, 1'b1, 1'b0);
    chk("lk_grant0", HGRANT, 4'b0010);
    cyc(4'b1010, 4'b0010, IDLE, SINGLE, 1'b1, 1'b0);
    chk("lk_master0", HMASTER, 1);
    chk("lk_mlock0", HMASTLOCK, 1);
    for (int i = 0; i < 9; i++) begin
      cyc((i == 8) ? 4'b1000 : 4'b1010, (i == 8) ? 4'b0000 : 4'b0010, lk_tr[i], INCR4, 1'b1, 1'b0);
      chk($sformatf("lk_grant_s%0d", i), HGRANT, (i == 8) ? 4'b1000 : 4'b0010);
      if (i < 8) chk($sformatf("lk_mlock_s%0d", i), HMASTLOCK, 1);
    end
    chk("lk_unlock", HMASTLOCK, 0);

    // ERROR on beat 2 of master 0's WRAP4
    do_reset();
    cyc(4'b0001, 4'b0, IDLE, SINGLE, 1'b1, 1'b0);
    chk("err_grant0", HGRANT, 4'b0001);
    cyc(4'b0011, 4'b0, NSEQ, WRAP4, 1'b1, 1'b0);
    chk("err_hold", HGRANT, 4'b0001);
    cyc(4'b0011, 4'b0, SEQ, WRAP4, 1'b1, 1'b1);
    chk("err_grant", HGRANT, 4'b0010);

    // master 0 long INCR with request held, master 2 waiting
    do_reset();
    cyc(4'b0001, 4'b0, IDLE, SINGLE, 1'b1, 1'b0);
    chk("ten_grant0", HGRANT, 4'b0001);
    for (int b = 1; b <= 17; b++) begin
      cyc(4'b0101, 4'b0, (b == 1) ? NSEQ : SEQ, INCR, 1'b1, 1'b0);
      if (b >= 15) chk($sformatf("ten_b%0d", b), HGRANT, (TEN && b >= 16) ? 4'b0100 : 4'b0001);
    end

    // asynchronous reset in the middle of a locked INCR4
    do_reset();
    cyc(4'b0010, 4'b0010, IDLE, SINGLE, 1'b1, 1'b0);
    cyc(4'b0010, 4'b0010, IDLE, SINGLE, 1'b1, 1'b0);
    cyc(4'b0010, 4'b0010, NSEQ, INCR4, 1'b1, 1'b0);
    cyc(4'b0010, 4'b0010, SEQ, INCR4, 1'b1, 1'b0);
    chk("ar_pre_grant", HGRANT, 4'b0010);
    chk("ar_pre_master", HMASTER, 1);
    chk("ar_pre_mlock", HMASTLOCK, 1);
    #2 HRST = 1'b0;
    #1;
    chk("ar_grant", HGRANT, 4'b0001);
    chk("ar_master", HMASTER, 0);
    chk("ar_mlock", HMASTLOCK, 0);
    HRST = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Multi-master AHB arbiter for the shared address/control bus that feeds the slave decoder and response multiplexor.
- Takes bus requests from up to MASTER_NUM masters and issues a one-hot HGRANT.
- Tracks burst progress from HTRANS/HBURST/HREADY so ownership moves only at legal AHB boundaries.
- Drives HMASTER (address-phase owner index) and HMASTLOCK.

Parameters:
MASTER_NUM, 4, number of requesting masters (2..8)
HBURST_WIDTH, 3, width of HBURST
DEFAULT_MASTER, 0, index parked on when no master requests
MAX_TENURE, 16, beat limit for INCR bursts (used only with AHB_ARB_TENURE_EN)

Ports:
HCLK  input  1  bus clock, rising edge
HRST  input  1  reset, asynchronous, active-low
HBUSREQ  input  MASTER_NUM  per-master bus request
HLOCK  input  MASTER_NUM  per-master locked-transfer request
HTRANS  input  2  current owner transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
HBURST  input  HBURST_WIDTH  current owner burst type, 0..7 per AHB encoding
HREADY  input  1  bus ready (muxed HREADYOUT)
HRESP  input  1  muxed response: 0 OKAY, 1 ERROR
HGRANT  output  MASTER_NUM  one-hot grant, registered
HMASTER  output  $clog2(MASTER_NUM)  address-phase owner index, registered
HMASTLOCK  output  1  current address phase is locked, registered

Behaviour:
- Reset (HRST=0, asynchronous, applied at any time including mid-burst): HGRANT=one-hot(DEFAULT_MASTER), HMASTER=DEFAULT_MASTER, HMASTLOCK=0, FSM=PARK, beat counter=0.
- Beat accepted: HREADY=1 and HTRANS is NONSEQ or SEQ. The counter loads 1 on NONSEQ and increments on SEQ.
- Burst length from HBURST:
  - 0 SINGLE = 1
  - 1 INCR = undefined
  - 2/3 = 4
  - 4/5 = 8
  - 6/7 = 16
- FSM states:
  - PARK: no requests; grant on DEFAULT_MASTER.
  - GRANT: grant issued; waiting for the owner's first NONSEQ.
  - BURST: fixed or INCR burst in progress.
  - LOCKED: owner holds HLOCK.
- Re-arbitration point (RP): a cycle with HREADY=1 and any of the following:
  - HTRANS=IDLE;
  - accepted beat is the last of a fixed-length burst (counter+1 == length, or SINGLE);
  - INCR burst with HBUSREQ[owner]=0;
  - HRESP=1 (ERROR terminates the burst).
- BUSY never forms an RP.
- At an RP:
  - If HLOCK[owner]=1, the grant is held and the FSM enters or stays in LOCKED.
  - Otherwise the next grant is round-robin: first index with HBUSREQ=1 searching owner+1, owner+2, ... wrapping modulo MASTER_NUM, with the owner itself checked last.
  - If no master requests, the grant parks on DEFAULT_MASTER (PARK).
- Outside an RP, HGRANT holds its value.
- Latency:
  - HGRANT changes on the rising edge ending the RP cycle.
  - HMASTER and HMASTLOCK update on the next rising edge where HREADY=1: HMASTER <= index of HGRANT, HMASTLOCK <= HLOCK[granted].
  - From an idle parked bus, a request at cycle N gives HGRANT at edge N+1 and HMASTER at edge N+2 when HREADY=1 throughout.
- HREADY=0 (wait states) freezes the counter, FSM, HGRANT and HMASTER.
- Simultaneous requests: round-robin order only; no fixed priority.
- In GRANT, HTRANS=IDLE with HREADY=1 from the newly granted master counts as an RP only when HBUSREQ[owner]=0. This prevents grant bounce before the first NONSEQ.
- HGRANT is always exactly one-hot; HMASTER is always a valid index below MASTER_NUM.

Optional Feature:
- Macro: AHB_ARB_TENURE_EN.
- Defined:
  - A tenure counter counts accepted beats of an INCR burst.
  - When it reaches MAX_TENURE and another master has HBUSREQ=1, that beat is an RP. The owner is de-granted even if HBUSREQ[owner]=1, unless HLOCK[owner]=1.
  - The counter clears on every grant change and on reset.
- Undefined: INCR bursts end only on the owner's request drop, IDLE or ERROR; no tenure counter is instantiated.

Test Plan:
- Reset then idle: HBUSREQ=0 -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0. Assert HRST=0 mid-INCR4 -> outputs return to these values without waiting for a clock edge.
- Round-robin: HBUSREQ=4'b1111, every master performs a SINGLE transfer, HREADY=1 -> grant sequence 0,1,2,3,0; each HMASTER value follows its HGRANT one cycle later.
- Fixed burst plus wait states:
  - Master 2 performs INCR8 with HBUSREQ=4'b0110 and HREADY=0 on beat 3 for 2 cycles -> HGRANT stays 4'b0100 through all 8 beats and the wait states.
  - It moves to 4'b0010 only at the edge ending beat 8.
- Lock: master 1 sets HLOCK=1 over two INCR4 bursts while master 3 requests -> HGRANT stays 4'b0010 and HMASTLOCK=1 for both bursts. Master 3 is granted at the first RP after HLOCK[1]=0.
- ERROR: HRESP=1 with HREADY=1 on beat 2 of master 0's WRAP4 while master 1 requests -> HGRANT=4'b0010 on the next edge.
- AHB_ARB_TENURE_EN defined, MAX_TENURE=16: master 0 runs INCR with HBUSREQ held while master 2 requests -> grant moves to master 2 after beat 16. With the macro undefined, master 0 keeps the bus.
